// File: rtl/cordic_pkg.sv
// Shared constants, state type and helpers for the CORDIC angle sequencer.
// Angle to the core is Q2.6, results from the core are Q1.7.
package cordic_pkg;

  localparam int ANGLE_W        = 8;   // width of core angle and results
  localparam int ANGLE_FRAC     = 6;   // Q2.6 angle fraction bits
  localparam int OUT_FRAC       = 7;   // Q1.7 sine/cosine fraction bits
  localparam int PHASE_W_DEF    = 10;  // default accumulator width
  localparam int CORDIC_LAT_DEF = 14;  // default core settle time in cycles
  localparam int K_SCALE_DEF    = 101; // round(2*pi*64/1024 * 256)
  localparam int SCALE_SHIFT    = 8;   // K_SCALE carries 8 extra fraction bits

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    CAPTURE
  } seq_state_e;

  // Two's-complement negate that maps the most negative code to the most
  // positive one instead of wrapping back onto itself.
  function automatic logic signed [ANGLE_W-1:0] sat_neg(
    input logic signed [ANGLE_W-1:0] x
  );
    if (x == {1'b1, {(ANGLE_W-1){1'b0}}})
      return {1'b0, {(ANGLE_W-1){1'b1}}};
    return -x;
  endfunction

endpackage

// File: rtl/cordic_phase_fold.sv
// Folds an unsigned full-circle phase into [-pi/2, pi/2) and scales it to a
// Q2.6 angle for the core. Quadrants 1 and 2 are rotated by pi, which flips
// the sign of both sine and cosine, so they report neg = 1.
module cordic_phase_fold
  import cordic_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int K_SCALE = K_SCALE_DEF
) (
  input  logic [PHASE_W-1:0]        ph,
  output logic signed [ANGLE_W-1:0] angle,
  output logic                      neg
);

  localparam int PROD_W = PHASE_W + 9;
  localparam logic [PHASE_W-1:0]       HALF    = PHASE_W'(1) << (PHASE_W - 1);
  localparam logic signed [PROD_W-1:0] K_S     = PROD_W'(K_SCALE);
  localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(1) << (SCALE_SHIFT - 1);

  logic [1:0]                 q;
  logic signed [PHASE_W-1:0]  f;
  logic signed [PROD_W-1:0]   f_ext;
  logic signed [PROD_W-1:0]   rounded;

  assign q = ph[PHASE_W-1 -: 2];

  // Fold into the convergent range; subtracting 2^PHASE_W in quadrant 3 is
  // just a signed reinterpretation of the same bits.
  always_comb begin
    f   = $signed(ph);
    neg = 1'b0;
    case (q)
      2'd1, 2'd2: begin
        f   = $signed(ph - HALF);
        neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign f_ext   = {{(PROD_W-PHASE_W){f[PHASE_W-1]}}, f};
  assign rounded = f_ext * K_S + ROUND_C;
  assign angle   = ANGLE_W'(rounded >>> SCALE_SHIFT);

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Sample-on-demand NCO front end for the iterative cordic core: keeps a
// phase accumulator, feeds the folded angle, pulses the core reset, waits
// CORDIC_LAT cycles, then captures quadrant-corrected sine/cosine.
// Optional build macro CORDIC_SEQ_AUTORUN_EN: start acts as a level enable
// and CAPTURE chains straight into ARM for a continuous sample stream.
module cordic_angle_sequencer
  import cordic_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int CORDIC_LAT = CORDIC_LAT_DEF,
  parameter int K_SCALE    = K_SCALE_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic [PHASE_W-1:0]        phase_init,
  output logic                      busy,
  output logic signed [ANGLE_W-1:0] cordic_in,
  output logic                      cordic_rst_n,
  input  logic signed [ANGLE_W-1:0] cordic_sine,
  input  logic signed [ANGLE_W-1:0] cordic_cosine,
  output logic signed [ANGLE_W-1:0] sine_out,
  output logic signed [ANGLE_W-1:0] cosine_out,
  output logic                      out_valid
);

  localparam int CNT_W = $clog2(CORDIC_LAT + 1);

  seq_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PHASE_W-1:0]        ph_q, ph_d, ph_fold;
  logic                      neg_q, neg_d;
  logic                      busy_d, valid_d, crst_n_d;
  logic signed [ANGLE_W-1:0] cordic_in_d, sine_d, cosine_d;
  logic signed [ANGLE_W-1:0] fold_angle;
  logic                      fold_neg;

  // In CAPTURE the next launch (autorun or a back-to-back start) must see the
  // advanced phase, so fold the post-increment value there.
  assign ph_fold = (state_q == CAPTURE) ? ph_q + phase_inc : ph_q;

  cordic_phase_fold #(
    .PHASE_W (PHASE_W),
    .K_SCALE (K_SCALE)
  ) u_fold (
    .ph    (ph_fold),
    .angle (fold_angle),
    .neg   (fold_neg)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every target gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    neg_d       = neg_q;
    busy_d      = busy;
    valid_d     = 1'b0;
    crst_n_d    = cordic_rst_n;
    cordic_in_d = cordic_in;
    sine_d      = sine_out;
    cosine_d    = cosine_out;

    case (state_q)
      IDLE: begin
        crst_n_d = 1'b1;
        busy_d   = 1'b0;
        if (start) begin
          state_d     = ARM;
          busy_d      = 1'b1;
          cordic_in_d = fold_angle;
          neg_d       = fold_neg;
          crst_n_d    = 1'b0;
        end
      end
      ARM: begin
        state_d  = RUN;
        cnt_d    = '0;
        crst_n_d = 1'b1;
      end
      RUN: begin
        if (cnt_q == CNT_W'(CORDIC_LAT - 1))
          state_d = CAPTURE;
        else
          cnt_d = cnt_q + CNT_W'(1);
      end
      CAPTURE: begin
        sine_d   = neg_q ? sat_neg(cordic_sine)   : cordic_sine;
        cosine_d = neg_q ? sat_neg(cordic_cosine) : cordic_cosine;
        valid_d  = 1'b1;
        ph_d     = ph_fold;
        busy_d   = 1'b0;
        state_d  = IDLE;
`ifdef CORDIC_SEQ_AUTORUN_EN
        if (start) begin
          state_d     = ARM;
          busy_d      = 1'b1;
          cordic_in_d = fold_angle;
          neg_d       = fold_neg;
          crst_n_d    = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset holds the core in reset and reloads
  // the accumulator from phase_init.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ph_q         <= phase_init;
      neg_q        <= 1'b0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      cordic_rst_n <= 1'b0;
      cordic_in    <= '0;
      sine_out     <= '0;
      cosine_out   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ph_q         <= ph_d;
      neg_q        <= neg_d;
      busy         <= busy_d;
      out_valid    <= valid_d;
      cordic_rst_n <= crst_n_d;
      cordic_in    <= cordic_in_d;
      sine_out     <= sine_d;
      cosine_out   <= cosine_d;
    end
  end

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed self-checking bench for cordic_angle_sequencer with a stub core
// whose sine/cosine are driven directly by the bench, plus a standalone
// check of cordic_phase_fold. Autorun vectors apply when
// CORDIC_SEQ_AUTORUN_EN is defined.
module tb_cordic_angle_sequencer;
  import cordic_pkg::*;

  localparam int PW = 10;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic [PW-1:0]             phase_inc = '0;
  logic [PW-1:0]             phase_init = '0;
  logic                      busy;
  logic signed [ANGLE_W-1:0] cordic_in;
  logic                      cordic_rst_n;
  logic signed [ANGLE_W-1:0] cordic_sine = '0;
  logic signed [ANGLE_W-1:0] cordic_cosine = '0;
  logic signed [ANGLE_W-1:0] sine_out;
  logic signed [ANGLE_W-1:0] cosine_out;
  logic                      out_valid;

  logic [PW-1:0]             fold_ph = '0;
  logic signed [ANGLE_W-1:0] fold_angle;
  logic                      fold_neg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_angle_sequencer #(
    .PHASE_W    (PW),
    .CORDIC_LAT (14),
    .K_SCALE    (101)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .phase_inc     (phase_inc),
    .phase_init    (phase_init),
    .busy          (busy),
    .cordic_in     (cordic_in),
    .cordic_rst_n  (cordic_rst_n),
    .cordic_sine   (cordic_sine),
    .cordic_cosine (cordic_cosine),
    .sine_out      (sine_out),
    .cosine_out    (cosine_out),
    .out_valid     (out_valid)
  );

  cordic_phase_fold #(
    .PHASE_W (PW),
    .K_SCALE (101)
  ) u_fold_ut (
    .ph    (fold_ph),
    .angle (fold_angle),
    .neg   (fold_neg)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fold_vec(input int ph, input int exp_angle, input int exp_neg);
    fold_ph = PW'(ph);
    #1;
    check($sformatf("fold_angle_%0d", ph), int'(fold_angle), exp_angle);
    check($sformatf("fold_neg_%0d", ph), int'(fold_neg), exp_neg);
  endtask

  // Holds rst for a cycle with the given phase_init, optionally checking the
  // reset values, then releases it and idles two cycles. Ends on a negedge.
  task automatic apply_reset(input int init, input bit check_outs);
    @(negedge clk);
    rst = 1'b1;
    phase_init = PW'(init);
    @(negedge clk);
    if (check_outs) begin
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_cordic_in", int'(cordic_in), 0);
      check("rst_cordic_rst_n", int'(cordic_rst_n), 0);
      check("rst_sine", int'(sine_out), 0);
      check("rst_cosine", int'(cosine_out), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Called on a negedge; pulses start for one edge (E0) and follows the
  // sample until out_valid. Returns in the out_valid cycle.
  task automatic run_sample(input string tag, input int exp_in,
                            input int exp_sin, input int exp_cos);
    int n;
    int low;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    low = 0;
    check({tag, "_cordic_in"}, int'(cordic_in), exp_in);
    check({tag, "_busy"}, int'(busy), 1);
    if (!cordic_rst_n) low++;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (!cordic_rst_n) low++;
    end
    check({tag, "_latency"}, n, 16);
    check({tag, "_rst_low"}, low, 1);
    check({tag, "_sine"}, int'(sine_out), exp_sin);
    check({tag, "_cosine"}, int'(cosine_out), exp_cos);
    check({tag, "_busy_done"}, int'(busy), 0);
  endtask

  initial begin
    int nv;

    // Standalone fold/scale vectors.
    fold_vec(0,      0, 0);
    fold_vec(128,   51, 0);
    fold_vec(255,  101, 0);
    fold_vec(256, -101, 1);
    fold_vec(384,  -50, 1);
    fold_vec(512,    0, 1);
    fold_vec(767,  101, 1);
    fold_vec(768, -101, 0);
    fold_vec(1000,  -9, 0);
    fold_vec(76,    30, 0);

    // Basic sample at phase 0.
    cordic_sine = 8'sd0;
    cordic_cosine = 8'sd127;
    apply_reset(0, 1'b1);
    run_sample("p0", 0, 0, 127);
    @(negedge clk);
    check("p0_valid_one_cycle", int'(out_valid), 0);

    // pi/4: no sign correction.
    cordic_sine = 8'sd90;
    cordic_cosine = 8'sd90;
    apply_reset(128, 1'b0);
    run_sample("p128", 51, 90, 90);

    // 3pi/4: folded to -pi/4, both results negated.
    cordic_sine = -8'sd90;
    cordic_cosine = 8'sd90;
    apply_reset(384, 1'b0);
    run_sample("p384", -50, 90, -90);

    // pi/2: folded to -pi/2, sine of -128 saturates to +127.
    cordic_sine = -8'sd128;
    cordic_cosine = 8'sd0;
    apply_reset(256, 1'b0);
    run_sample("p256", -101, 127, 0);

    // pi: cosine negated, then the -128 saturation case.
    cordic_sine = 8'sd0;
    cordic_cosine = 8'sd127;
    apply_reset(512, 1'b0);
    run_sample("p512", 0, 0, -127);
    cordic_cosine = -8'sd128;
    apply_reset(512, 1'b0);
    run_sample("p512_sat", 0, 0, 127);

    // Wrap: 1000 + 100 = 76 mod 1024; second start lands in the out_valid
    // cycle and must use the updated phase.
    cordic_sine = 8'sd5;
    cordic_cosine = 8'sd10;
    phase_inc = PW'(100);
    apply_reset(1000, 1'b0);
    run_sample("wrap1", -9, 5, 10);
    run_sample("wrap2", 30, 5, 10);
    phase_inc = '0;

    // start pulsed during RUN is ignored: exactly one out_valid.
    cordic_sine = 8'sd0;
    cordic_cosine = 8'sd127;
    apply_reset(0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("ignored_start_valids", nv, 1);
    check("ignored_start_cosine", int'(cosine_out), 127);

    // rst mid-RUN: outputs return to reset values, no out_valid, and the
    // accumulator reloads from phase_init.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    phase_init = PW'(128);
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_cordic_rst_n", int'(cordic_rst_n), 0);
    check("midrst_cosine", int'(cosine_out), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst_no_valid", nv, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_cordic_in_idle", int'(cordic_in), 0);
    run_sample("after_rst", 51, 0, 127);

`ifdef CORDIC_SEQ_AUTORUN_EN
    // Autorun: start held 50 cycles gives samples 16 cycles apart with the
    // phase stepping by 64 each time (angles 0, 25, 51, 76).
    begin
      int last;
      int gap_ok;
      int ins[$];
      phase_inc = PW'(64);
      apply_reset(0, 1'b0);
      start = 1'b1;
      nv = 0;
      last = -1;
      gap_ok = 1;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (i == 50) start = 1'b0;
        if (!cordic_rst_n) ins.push_back(int'(cordic_in));
        if (out_valid) begin
          nv++;
          if (last >= 0 && i - last != 16) gap_ok = 0;
          last = i;
        end
      end
      check("auto_valids", nv, 4);
      check("auto_period", gap_ok, 1);
      check("auto_launches", ins.size(), 4);
      if (ins.size() == 4) begin
        check("auto_in0", ins[0], 0);
        check("auto_in1", ins[1], 25);
        check("auto_in2", ins[2], 51);
        check("auto_in3", ins[3], 76);
      end
      phase_inc = '0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
